// File: rtl/register_file_sb.sv
// register_file_sb: 2-read/2-write register file with hardwired r0, pending-write scoreboard and sweep clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy) onto the read ports.
module register_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int N_REG  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              clr_busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs [1:N_REG-1];
  logic [N_REG-1:1]  pend;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_idx  <= '0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        state    <= CLEAR;
        clr_busy <= 1'b1;
        clr_idx  <= ADDR_W'(1);
      end
    end else begin
      clr_idx <= clr_idx + ADDR_W'(1);
      if (clr_idx == ADDR_W'(N_REG - 1)) begin
        state    <= IDLE;
        clr_busy <= 1'b0;
      end
    end
  // Register 0 has no storage; index 1..N_REG-1 each own a data word and a pending bit.
  for (genvar g = 1; g < N_REG; g++) begin : g_reg
    logic [DATA_W-1:0] q;
    logic              p;
    logic              hit0, hit1, hit_r;
    assign hit0 = wr_en_0 && wr_addr_0 == ADDR_W'(g);
    assign hit1 = wr_en_1 && wr_addr_1 == ADDR_W'(g);
    assign hit_r = rsv_en && rsv_addr == ADDR_W'(g);
    always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
        q <= '0;
        p <= 1'b0;
      end else if (clr_busy) begin
        if (clr_idx == ADDR_W'(g)) begin
          q <= '0;
          p <= 1'b0;
        end
      end else begin
        if (hit0 || hit1) q <= hit1 ? wr_data_1 : wr_data_0;
        if (hit0 || hit1 || hit_r) p <= hit_r;
      end
    assign regs[g] = q;
    assign pend[g] = p;
  end
  // Returns {busy, data}; unmatched addresses (0 and >= N_REG) read as zero.
  function automatic logic [DATA_W:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = '0;
    for (int i = 1; i < N_REG; i++) r = (a == ADDR_W'(i)) ? {pend[i], regs[i]} : r;
`ifdef REGFILE_BYPASS_EN
    if (!clr_busy && a != '0 && int'(a) < N_REG)
      r = (wr_en_1 && wr_addr_1 == a) ? {rsv_en && rsv_addr == a, wr_data_1} :
          (wr_en_0 && wr_addr_0 == a) ? {rsv_en && rsv_addr == a, wr_data_0} : r;
`endif
    return r;
  endfunction
  always_comb begin
    {rd_busy_a, rd_data_a} = rd_port(rd_addr_a);
    {rd_busy_b, rd_data_b} = rd_port(rd_addr_b);
  end
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed and randomized checks of register_file_sb against an array-based reference model.
module tb_register_file_sb;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int N  = 32;
  logic          clk = 1'b0;
  logic          arst_n;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_busy_a, rd_busy_b;
  logic          wr_en_0, wr_en_1;
  logic [AW-1:0] wr_addr_0, wr_addr_1;
  logic [DW-1:0] wr_data_0, wr_data_1;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          clr_req;
  logic          clr_busy;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_reg [N];
  logic          m_pend [N];
  logic          m_clr;
  int            m_idx;
  always #50 clk = ~clk;
  register_file_sb dut (
    .clk(clk), .arst_n(arst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en_0(wr_en_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_clr = 1'b0;
    m_idx = 0;
  endtask
  task automatic idle();
    wr_en_0 = 1'b0;
    wr_en_1 = 1'b0;
    rsv_en = 1'b0;
    clr_req = 1'b0;
  endtask
  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_0 = 1'b1;
    wr_addr_0 = a;
    wr_data_0 = d;
  endtask
  // Architectural effect of one clock edge: sweep one index, or apply port 0, then port 1, then the reservation.
  task automatic model_edge();
    if (!arst_n) return;
    if (m_clr) begin
      m_reg[m_idx] = '0;
      m_pend[m_idx] = 1'b0;
      if (m_idx == N - 1) m_clr = 1'b0;
      m_idx++;
    end else begin
      if (clr_req) begin
        m_clr = 1'b1;
        m_idx = 1;
      end
      if (wr_en_0 && wr_addr_0 != 0) begin
        m_reg[wr_addr_0] = wr_data_0;
        m_pend[wr_addr_0] = 1'b0;
      end
      if (wr_en_1 && wr_addr_1 != 0) begin
        m_reg[wr_addr_1] = wr_data_1;
        m_pend[wr_addr_1] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  endtask
  function automatic logic [DW:0] exp_rd(input logic [AW-1:0] a);
    logic [DW:0] r;
    if (a == 0) return '0;
    r = {m_pend[a], m_reg[a]};
`ifdef REGFILE_BYPASS_EN
    if (!m_clr) begin
      if (wr_en_1 && wr_addr_1 == a) r = {rsv_en && rsv_addr == a, wr_data_1};
      else if (wr_en_0 && wr_addr_0 == a) r = {rsv_en && rsv_addr == a, wr_data_0};
    end
`endif
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("clr_busy", clr_busy, m_clr);
  endtask
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [DW:0] ea, eb;
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
    ea = exp_rd(a);
    eb = exp_rd(b);
    chk({tag, "_data_a"}, rd_data_a, ea[DW-1:0]);
    chk({tag, "_busy_a"}, rd_busy_a, ea[DW]);
    chk({tag, "_data_b"}, rd_data_b, eb[DW-1:0]);
    chk({tag, "_busy_b"}, rd_busy_b, eb[DW]);
  endtask
  task automatic sweep(input string tag);
    for (int a = 0; a < N; a++) rd_chk(tag, AW'(a), AW'(N - 1 - a));
  endtask
  initial begin
    int n;
    idle();
    wr_addr_0 = '0; wr_addr_1 = '0; wr_data_0 = '0; wr_data_1 = '0; rsv_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    model_reset();
    arst_n = 1'b0;
    #10;
    chk("rst_clr_busy", clr_busy, 0);
    sweep("rst");
    arst_n = 1'b1;
    // Dual-port collision and register 0
    wr0(5, 16'h1111);
    wr_en_1 = 1'b1; wr_addr_1 = 5; wr_data_1 = 16'h2222;
    tick(); idle();
    rd_chk("dual", 5, 5);
    chk("dual_const", rd_data_a, 16'h2222);
    wr0(0, 16'hBEEF);
    tick(); idle();
    rd_chk("r0", 0, 0);
    chk("r0_const", rd_data_a, 0);
    // Scoreboard
    rsv_en = 1'b1; rsv_addr = 7;
    tick(); idle();
    rd_chk("rsv", 7, 7);
    chk("rsv_busy_const", rd_busy_a, 1);
    wr0(7, 16'h00AA);
    tick(); idle();
    rd_chk("rsv_wr", 7, 7);
    chk("rsv_wr_busy_const", rd_busy_a, 0);
    chk("rsv_wr_data_const", rd_data_a, 16'h00AA);
    wr0(9, 16'h3C3C); rsv_en = 1'b1; rsv_addr = 9;
    tick(); idle();
    rd_chk("wr_rsv", 9, 9);
    chk("wr_rsv_busy_const", rd_busy_a, 1);
    chk("wr_rsv_data_const", rd_data_a, 16'h3C3C);
    // Same-cycle read of a write
    wr0(3, 16'h0101);
    tick(); idle();
    wr0(3, 16'h1234);
    rd_chk("byp_same", 3, 3);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_const", rd_data_a, 16'h1234);
`else
    chk("byp_same_const", rd_data_a, 16'h0101);
`endif
    tick(); idle();
    rd_chk("byp_next", 3, 3);
    chk("byp_next_const", rd_data_a, 16'h1234);
    // Clear sweep
    for (int a = 1; a < N; a++) begin
      wr0(AW'(a), 16'hFFFF);
      tick();
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 4;
    tick(); idle();
    rd_chk("pre_clr", 4, 2);
    clr_req = 1'b1;
    tick(); idle();
    n = 0;
    while (clr_busy && n < 100) begin
      n++;
      wr_en_0 = (n == 3);
      wr_addr_0 = 2;
      wr_data_0 = 16'h5555;
      if (n == 15) sweep("mid_clr");
      tick();
    end
    idle();
    chk("clr_len", n, 31);
    sweep("post_clr");
    rd_addr_a = 2; rd_addr_b = 4;
    #1;
    chk("clr_r2_const", rd_data_a, 0);
    chk("clr_r4_busy_const", rd_busy_b, 0);
    // Reset in the middle of a sweep
    for (int a = 1; a < N; a++) begin
      wr0(AW'(a), DW'($urandom));
      tick();
    end
    idle();
    clr_req = 1'b1;
    tick(); idle();
    repeat (10) tick();
    rd_chk("pre_rst", 5, 30);
    #5;
    arst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", clr_busy, 0);
    sweep("mid_rst");
    #5;
    arst_n = 1'b1;
    wr0(6, 16'h4321);
    tick(); idle();
    rd_chk("post_rst", 6, 6);
    chk("post_rst_const", rd_data_a, 16'h4321);
    // Randomized traffic
    repeat (400) begin
      wr_en_0 = 1'($urandom_range(0, 1));
      wr_addr_0 = AW'($urandom_range(0, N - 1));
      wr_data_0 = DW'($urandom);
      wr_en_1 = 1'($urandom_range(0, 1));
      wr_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr_0 : AW'($urandom_range(0, N - 1));
      wr_data_1 = DW'($urandom);
      rsv_en = 1'($urandom_range(0, 1));
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr_1 : AW'($urandom_range(0, N - 1));
      clr_req = ($urandom_range(0, 59) == 0);
      rd_chk("rnd", ($urandom_range(0, 1) == 0) ? wr_addr_0 : AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
      tick();
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
